// File: rtl/mdu_scheduler.sv
// Multiply/divide unit with busy-counter sequencing, HI/LO ownership and D-stage stall request.
// Optional macro MDU_MADD_EN enables madd/maddu accumulation into {hi,lo}.
module mdu_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  op_r, op_s;
    logic [31:0] a_r, a_s, b_r, b_s;
    logic [31:0] hi_r, hi_s, lo_r, lo_s;
    logic        busy_r;

    logic        signed_op_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [31:0] abs_a_s, abs_b_s, div_den_s, q_mag_s, r_mag_s, quot_s, rem_s;
`ifdef MDU_MADD_EN
    logic [63:0] acc_s;
`endif

    // Datapath: one shared operand sign mode for the multiplier and divider.
    always_comb begin
`ifdef MDU_MADD_EN
        signed_op_s = (op_r == OP_MULT) || (op_r == OP_DIV) || (op_r == OP_MADD);
`else
        signed_op_s = (op_r == OP_MULT) || (op_r == OP_DIV);
`endif
        // Sign/zero extension to 64 bits makes the truncated product exact.
        mul_a_s   = signed_op_s ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        mul_b_s   = signed_op_s ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        prod_s    = mul_a_s * mul_b_s;
`ifdef MDU_MADD_EN
        acc_s     = {hi_r, lo_r} + prod_s;
`endif
        abs_a_s   = (signed_op_s && a_r[31]) ? (32'd0 - a_r) : a_r;
        abs_b_s   = (signed_op_s && b_r[31]) ? (32'd0 - b_r) : b_r;
        div_den_s = (b_r == 32'd0) ? 32'd1 : abs_b_s;
        q_mag_s   = abs_a_s / div_den_s;
        r_mag_s   = abs_a_s % div_den_s;
        quot_s    = (signed_op_s && (a_r[31] ^ b_r[31])) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s     = (signed_op_s && a_r[31]) ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Next-state, counter, operand latch and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        a_s     = a_r;
        b_s     = b_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
                        , OP_MADD, OP_MADDU
`endif
                        : begin
                            state_s = ST_MUL;
                            cnt_s   = 4'(MULT_CYCLES);
                            op_s    = op;
                            a_s     = rs_val;
                            b_s     = rt_val;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_s = ST_DIV;
                            cnt_s   = 4'(DIV_CYCLES);
                            op_s    = op;
                            a_s     = rs_val;
                            b_s     = rt_val;
                        end
                        OP_MTHI: hi_s = rs_val;
                        OP_MTLO: lo_s = rs_val;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
`ifdef MDU_MADD_EN
                    if ((op_r == OP_MADD) || (op_r == OP_MADDU)) begin
                        {hi_s, lo_s} = acc_s;
                    end else begin
                        {hi_s, lo_s} = prod_s;
                    end
`else
                    {hi_s, lo_s} = prod_s;
`endif
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    // A zero divisor still consumes the full latency but leaves HI/LO alone.
                    if (b_r != 32'd0) begin
                        hi_s = rem_s;
                        lo_s = quot_s;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    state_s = ST_DIV;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            a_r     <= a_s;
            b_r     <= b_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign busy     = busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign stall_md = md_in_D & (start | busy_r);

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Multiply/divide unit plus its sequencing controller, sitting in the E stage beside the ALU.
- Accepts one MDU operation per start pulse and models the multi-cycle latency with a busy counter. Owns the HI/LO registers.
- Drives the stall request that the hazard unit ORs into its D-stage stall, so MDU-class instructions wait while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd/maddu when enabled); legal range 1..15
DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  E-stage instruction is an MDU op; qualifies op
op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; others none
rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
md_in_D  input  1  D-stage instruction is MDU-class (any op above, or mfhi/mflo)
busy  output  1  operation in flight
stall_md  output  1  = md_in_D & (start | busy), combinational
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- The state machine has three states: IDLE, MUL, DIV. There is a 4-bit down counter cnt and latched operand registers a and b.
- Reset (reset==0 at a rising edge) forces:
  - state=IDLE, cnt=0, busy=0, hi=0, lo=0;
  - latched operands cleared.
  - Reset during MUL/DIV aborts the operation; no HI/LO commit.
- IDLE transitions:
  - start with op 1/2/7/8: latch a=rs_val, b=rt_val, go to MUL, cnt=MULT_CYCLES.
  - start with op 3/4: latch operands, go to DIV, cnt=DIV_CYCLES.
  - start with op 5 (mthi): hi<=rs_val at this edge; stay IDLE; busy stays 0.
  - start with op 6 (mtlo): lo<=rs_val at this edge; stay IDLE; busy stays 0.
- MUL/DIV transitions:
  - cnt decrements each edge.
  - On the edge where cnt goes 1->0: commit the result, return to IDLE, busy<=0.
- busy is registered and equals (state!=IDLE). It is high for exactly N cycles after the start edge, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO are not written while busy; they are written only at the commit edge.
- start while busy: ignored entirely (hazard unit guarantees this never happens; the bench checks it is harmless).
- Arithmetic:
  - mult: signed 32x32 -> 64; {hi,lo}=product.
  - multu: unsigned 32x32 -> 64.
  - div: signed; lo=quotient truncated toward zero; hi=remainder, which takes the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned quotient/remainder.
  - Divisor==0 (div or divu): the full busy period still elapses; hi/lo are left unchanged.
- stall_md covers the start cycle as well as the busy cycles, so an instruction in D behind a just-issued MDU op stalls immediately.
- mfhi/mflo read hi/lo directly; the stall rule guarantees they are never read stale.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 7 (madd): {hi,lo} <= {hi,lo} + signed(a)*signed(b), committed at the same edge and with the same MULT_CYCLES latency as mult.
  - op 8 (maddu): the same accumulation with an unsigned product.
  - The accumulator value is sampled at the commit edge.
- Undefined: ops 7/8 are treated as op 0, i.e. no state change and no busy.

Test Plan:
- mult, rs=0xFFFFFFFD (-3), rt=5 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo keep their old values throughout busy.
- divu, rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2. div, rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div, rs=0x12345678, rt=0, with hi=0xAAAA0000 and lo=0x0000BBBB preloaded via mthi/mtlo -> busy 10 cycles; hi/lo unchanged afterwards.
- Stall: start mult with md_in_D=1 held -> stall_md=1 on the start cycle plus 5 busy cycles, then 0. md_in_D=0 gives stall_md=0 throughout. A second start during busy is ignored.
- Reset: drive reset=0 at busy cycle 4 of a div -> next edge busy=0, hi=lo=0. A subsequent mtlo rs=0x5 gives lo=5 after one edge with busy never asserting.
- MDU_MADD_EN build: hi=0, lo=0xFFFFFFFF, then madd rs=1, rt=1 -> after 5 cycles hi=1, lo=0. Non-MADD build: same stimulus leaves busy=0 and hi/lo unchanged.
